bcd_updown_counter_n: RTL and testbench

Parametrised multi-digit BCD up/down counter with synchronous clear, parallel load, count enable and wrap indication. It replaces single-digit 0–9 counters in display and timer paths. It is cascadable through `ovf` into a further instance, and feeds seven-segment decoders directly, one nibble per digit.

---
 rtl/bcd_updown_counter_n_pkg.sv | 12 +
 rtl/bcd_updown_counter_n_if.sv | 24 ++
 rtl/bcd_updown_counter_n_digit.sv | 37 +++
 rtl/bcd_updown_counter_n.sv | 69 ++++++
 tb/tb_bcd_updown_counter_n.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_updown_counter_n_pkg.sv
// Shared BCD constants and the load-saturation helper used by the counter and its digits.
package bcd_pkg;

    localparam int         BCD_W   = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_MIN = 4'd0;

    function automatic logic [BCD_W-1:0] bcd_sat(input logic [BCD_W-1:0] nibble);
        return (nibble > BCD_MAX) ? BCD_MAX : nibble;
    endfunction

endpackage

// File: rtl/bcd_updown_counter_n_if.sv
// Control/data bundle of the BCD counter; names are from the counter's point of view.
interface bcd_updown_counter_n_if #(
    parameter int DIGITS = 4
);
    logic                  i_clr;
    logic                  i_load;
    logic [4*DIGITS-1:0]   i_d;
    logic                  i_en;
    logic                  i_up;
    logic [4*DIGITS-1:0]   o_q;
    logic                  o_tc;
    logic                  o_ovf;
    logic                  o_load_err;

    modport slave (
        input  i_clr, i_load, i_d, i_en, i_up,
        output o_q, o_tc, o_ovf, o_load_err
    );

    modport master (
        output i_clr, i_load, i_d, i_en, i_up,
        input  o_q, o_tc, o_ovf, o_load_err
    );
endinterface

// File: rtl/bcd_updown_counter_n_digit.sv
// One BCD digit: clear/load/step with carry-out when stepping past its limit.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [BCD_W-1:0] i_d_in,
    input  logic             i_ci,
    input  logic             i_up,
    output logic [BCD_W-1:0] o_q,
    output logic             o_co
);

    logic [BCD_W-1:0] r_q;
    logic             w_at_lim;

    assign w_at_lim = i_up ? (r_q == BCD_MAX) : (r_q == BCD_MIN);
    assign o_co     = i_ci & w_at_lim;
    assign o_q      = r_q;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_q <= BCD_MIN;
        end else if (i_load) begin
            r_q <= bcd_sat(i_d_in);
        end else if (i_ci) begin
            if (i_up) begin
                r_q <= (r_q == BCD_MAX) ? BCD_MIN : r_q + 4'd1;
            end else begin
                r_q <= (r_q == BCD_MIN) ? BCD_MAX : r_q - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_updown_counter_n.sv
// Multi-digit BCD up/down counter: ripple carry chain of bcd_digit, wrap pulse and load-error flag.
module bcd_updown_counter_n
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    bcd_updown_counter_n_if.slave  bus
);

    logic [DIGITS:0]         w_carry;
    logic [DIGITS-1:0]       w_lim;
    logic [4*DIGITS-1:0]     w_q;
    logic                    w_bad_nib;
    logic                    r_ovf;
    logic                    r_load_err;

    assign w_carry[0] = bus.i_en;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        logic [BCD_W-1:0] w_dq;

        bcd_digit u_digit (
            .i_clk  (i_clk),
            .i_rst  (i_rst),
            .i_clr  (bus.i_clr),
            .i_load (bus.i_load),
            .i_d_in (bus.i_d[BCD_W*gi +: BCD_W]),
            .i_ci   (w_carry[gi]),
            .i_up   (bus.i_up),
            .o_q    (w_dq),
            .o_co   (w_carry[gi+1])
        );

        assign w_q[BCD_W*gi +: BCD_W] = w_dq;
        assign w_lim[gi] = bus.i_up ? (w_dq == BCD_MAX) : (w_dq == BCD_MIN);
    end

    always_comb begin
        w_bad_nib = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.i_d[BCD_W*i +: BCD_W] > BCD_MAX) begin
                w_bad_nib = 1'b1;
            end
        end
    end

    // Carry out of the top digit already includes en, so it is exactly the wrap edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ovf      <= 1'b0;
            r_load_err <= 1'b0;
        end else if (bus.i_clr) begin
            r_ovf      <= 1'b0;
        end else if (bus.i_load) begin
            r_ovf      <= 1'b0;
            r_load_err <= w_bad_nib;
        end else begin
            r_ovf      <= w_carry[DIGITS];
        end
    end

    assign bus.o_q        = w_q;
    assign bus.o_tc       = &w_lim;
    assign bus.o_ovf      = r_ovf;
    assign bus.o_load_err = r_load_err;

endmodule

// File: tb/tb_bcd_updown_counter_n.sv
// Bench for bcd_updown_counter_n: decimal-integer reference model checked every cycle, plus directed literals.
module tb_bcd_updown_counter_n;

    localparam int DIGITS = 3;
    localparam int MAXV   = 999;

    logic clk = 1'b0;
    logic rst = 1'b1;

    bcd_updown_counter_n_if #(.DIGITS(DIGITS)) bus ();

    bcd_updown_counter_n #(.DIGITS(DIGITS)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int m_val   = 0;
    bit m_ovf   = 0;
    bit m_err   = 0;
    bit m_valid = 0;

    function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
        logic [4*DIGITS-1:0] r;
        int t;
        t = v;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the count is a plain decimal integer.
    always @(posedge clk) begin
        if (rst) begin
            m_val = 0; m_ovf = 0; m_err = 0; m_valid = 1;
        end else if (bus.i_clr) begin
            m_val = 0; m_ovf = 0;
        end else if (bus.i_load) begin
            int nib;
            m_val = 0; m_err = 0; m_ovf = 0;
            for (int i = DIGITS - 1; i >= 0; i--) begin
                nib = int'(bus.i_d[4*i +: 4]);
                if (nib > 9) begin
                    m_err = 1;
                    nib = 9;
                end
                m_val = m_val * 10 + nib;
            end
        end else if (bus.i_en) begin
            if (bus.i_up) begin
                m_ovf = (m_val == MAXV);
                m_val = (m_val == MAXV) ? 0 : m_val + 1;
            end else begin
                m_ovf = (m_val == 0);
                m_val = (m_val == 0) ? MAXV : m_val - 1;
            end
        end else begin
            m_ovf = 0;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_q", 32'(bus.o_q), 32'(to_bcd(m_val)));
            chk("model_ovf", 32'(bus.o_ovf), 32'(m_ovf));
            chk("model_load_err", 32'(bus.o_load_err), 32'(m_err));
            chk("model_tc", 32'(bus.o_tc),
                32'(bus.i_up ? (m_val == MAXV) : (m_val == 0)));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.i_clr = 0; bus.i_load = 0; bus.i_en = 0;
    endtask

    task automatic do_load(input logic [4*DIGITS-1:0] v);
        idle();
        bus.i_load = 1; bus.i_d = v;
        cyc();
        bus.i_load = 0;
    endtask

    initial begin
        int ovf_cnt;
        int r;
        logic [4*DIGITS-1:0] dv;

        bus.i_clr = 0; bus.i_load = 0; bus.i_en = 0; bus.i_up = 0; bus.i_d = '0;
        cyc();
        rst = 0;
        #1;
        chk("rst_q", 32'(bus.o_q), 32'h000);
        chk("rst_ovf", 32'(bus.o_ovf), 32'd0);
        chk("rst_err", 32'(bus.o_load_err), 32'd0);
        chk("rst_tc_down", 32'(bus.o_tc), 32'd1);
        bus.i_up = 1;
        #1;
        chk("rst_tc_up", 32'(bus.o_tc), 32'd0);

        // Full up-count sweep 000..999 and back to 000
        bus.i_en = 1;
        ovf_cnt = 0;
        for (int i = 0; i < 999; i++) begin
            cyc();
            if (bus.o_ovf) ovf_cnt++;
        end
        chk("up_at_999", 32'(bus.o_q), 32'h999);
        chk("up_tc_999", 32'(bus.o_tc), 32'd1);
        cyc();
        chk("up_wrap_q", 32'(bus.o_q), 32'h000);
        chk("up_wrap_ovf", 32'(bus.o_ovf), 32'd1);
        chk("up_no_early_ovf", 32'(ovf_cnt), 32'd0);
        cyc();
        chk("up_ovf_one_cycle", 32'(bus.o_ovf), 32'd0);
        chk("up_after_wrap", 32'(bus.o_q), 32'h001);

        // Down count from 010
        do_load(12'h010);
        bus.i_up = 0; bus.i_en = 1;
        cyc();
        chk("down_first", 32'(bus.o_q), 32'h009);
        for (int i = 0; i < 9; i++) cyc();
        chk("down_zero", 32'(bus.o_q), 32'h000);
        chk("down_tc", 32'(bus.o_tc), 32'd1);
        cyc();
        chk("down_wrap_q", 32'(bus.o_q), 32'h999);
        chk("down_wrap_ovf", 32'(bus.o_ovf), 32'd1);
        cyc();
        chk("down_ovf_drop", 32'(bus.o_ovf), 32'd0);

        // Direction flip 019 -> 020 -> 019
        do_load(12'h019);
        bus.i_en = 1; bus.i_up = 1;
        cyc();
        chk("flip_up", 32'(bus.o_q), 32'h020);
        bus.i_up = 0;
        cyc();
        chk("flip_down", 32'(bus.o_q), 32'h019);
        chk("flip_ovf", 32'(bus.o_ovf), 32'd0);

        // Invalid load saturates; clr keeps load_err; valid load clears it
        do_load(12'hA3F);
        chk("bad_load_q", 32'(bus.o_q), 32'h939);
        chk("bad_load_err", 32'(bus.o_load_err), 32'd1);
        idle(); bus.i_clr = 1;
        cyc();
        bus.i_clr = 0;
        chk("clr_keeps_err", 32'(bus.o_load_err), 32'd1);
        do_load(12'h123);
        chk("good_load_err", 32'(bus.o_load_err), 32'd0);

        // Priority: clr over load and en; rst over counting at the wrap
        do_load(12'h999);
        bus.i_up = 1; bus.i_clr = 1; bus.i_load = 1; bus.i_d = 12'h555; bus.i_en = 1;
        cyc();
        chk("prio_clr_q", 32'(bus.o_q), 32'h000);
        chk("prio_clr_ovf", 32'(bus.o_ovf), 32'd0);
        do_load(12'h999);
        bus.i_en = 1; rst = 1;
        cyc();
        rst = 0;
        chk("prio_rst_q", 32'(bus.o_q), 32'h000);
        chk("prio_rst_ovf", 32'(bus.o_ovf), 32'd0);

        // Load wins over en
        do_load(12'h998);
        bus.i_load = 1; bus.i_d = 12'h500; bus.i_en = 1;
        cyc();
        chk("load_over_en", 32'(bus.o_q), 32'h500);

        // Hold with up toggling
        do_load(12'h042);
        for (int i = 0; i < 10; i++) begin
            bus.i_up = ~bus.i_up;
            cyc();
            chk("hold_q", 32'(bus.o_q), 32'h042);
            chk("hold_tc", 32'(bus.o_tc), 32'd0);
        end

        // Randomised traffic, checked by the model
        for (int i = 0; i < 4000; i++) begin
            r = int'($urandom_range(0, 255));
            rst        = (r < 3);
            bus.i_clr  = (r >= 3 && r < 9);
            bus.i_load = (r >= 9 && r < 40);
            bus.i_en   = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) bus.i_up = ~bus.i_up;
            case ($urandom_range(0, 3))
                0: dv = 12'($urandom);
                1: dv = bus.i_up ? 12'h998 : 12'h001;
                default: begin
                    for (int k = 0; k < DIGITS; k++) dv[4*k +: 4] = 4'($urandom_range(0, 9));
                end
            endcase
            bus.i_d = dv;
            cyc();
        end
        rst = 0;
        idle();
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
